relu_mask_buffer: RTL and testbench

Streaming ReLU mask store-and-replay stage that feeds the ReLU backward path in the CNN training pipeline. During the forward pass it records one mask bit per activation, where the bit means "pre-activation strictly positive". During the backward pass it replays those bits to gate the incoming gradient stream. Gated gradients leave through a registered valid/ready output toward the backward stage. Full activation words are never stored, so only DEPTH bits of state are held per layer.

---
 rtl/relu_mask_buffer_if.sv | 28 ++
 rtl/relu_mask_buffer.sv | 118 +++++++++++
 tb/tb_relu_mask_buffer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_mask_buffer_if.sv
// relu_mask_buffer_if: forward-mask, backward-gradient and gated-output
// streams of the ReLU mask buffer, plus the stored-mask count.
// The slave modport is the buffer; the master modport drives it.
interface relu_mask_buffer_if #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
);
  logic          fwd_valid;
  logic [31:0]   fwd_data;
  logic          fwd_ready;
  logic          bwd_valid;
  logic [31:0]   bwd_grad;
  logic          bwd_ready;
  logic          out_valid;
  logic [31:0]   out_grad;
  logic          out_ready;
  logic [AW:0]   mask_count;

  modport slave (
    input  fwd_valid, fwd_data, bwd_valid, bwd_grad, out_ready,
    output fwd_ready, bwd_ready, out_valid, out_grad, mask_count
  );

  modport master (
    output fwd_valid, fwd_data, bwd_valid, bwd_grad, out_ready,
    input  fwd_ready, bwd_ready, out_valid, out_grad, mask_count
  );
endinterface

// File: rtl/relu_mask_buffer.sv
// relu_mask_buffer: records one "pre-activation > 0" bit per forward
// activation and replays the bits to gate the backward gradient stream.
// Only DEPTH mask bits are held; full activation words are never stored.
// Optional feature: define RELU_MASK_LIFO_EN for last-in-first-out replay
// (single stack pointer, pop has priority over push). Default is FIFO.
module relu_mask_buffer #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  relu_mask_buffer_if.slave    bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mask_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
`ifndef RELU_MASK_LIFO_EN
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
`endif
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_grad_q, out_grad_d;

  logic fwd_mask, rd_mask, fwd_ready_c, bwd_ready_c, fwd_fire, bwd_fire;

  // Positive, non-zero magnitude; -0.0 and all negatives give 0, +NaN/+Inf give 1.
  assign fwd_mask = ~bus.fwd_data[31] & (|bus.fwd_data[30:0]);

  // The output register frees up when empty or being drained this cycle.
  assign bwd_ready_c = (count_q != '0) & (~out_valid_q | bus.out_ready);

`ifdef RELU_MASK_LIFO_EN
  // Pop wins: a push is refused whenever a pop is taking place.
  assign fwd_ready_c = (count_q != FULL_CNT) & ~(bus.bwd_valid & bwd_ready_c);
  assign rd_mask     = mask_q[wr_ptr_q - AW'(1)];
`else
  assign fwd_ready_c = (count_q != FULL_CNT);
  assign rd_mask     = mask_q[rd_ptr_q];
`endif

  // clear suppresses both handshakes so nothing is written or read.
  assign fwd_fire = bus.fwd_valid & fwd_ready_c & ~clear;
  assign bwd_fire = bus.bwd_valid & bwd_ready_c & ~clear;

  assign bus.fwd_ready  = fwd_ready_c;
  assign bus.bwd_ready  = bwd_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_grad   = out_grad_q;
  assign bus.mask_count = count_q;

  // Next-state for pointers, occupancy and the registered output.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
`ifndef RELU_MASK_LIFO_EN
    rd_ptr_d    = rd_ptr_q;
`endif
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_grad_d  = out_grad_q;
    if (clear) begin
      wr_ptr_d    = '0;
`ifndef RELU_MASK_LIFO_EN
      rd_ptr_d    = '0;
`endif
      count_d     = '0;
      out_valid_d = 1'b0;
      out_grad_d  = '0;
    end else begin
      if (fwd_fire) wr_ptr_d = wr_ptr_q + AW'(1);
`ifdef RELU_MASK_LIFO_EN
      if (bwd_fire) wr_ptr_d = wr_ptr_q - AW'(1);
`else
      if (bwd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
`endif
      case ({fwd_fire, bwd_fire})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (bwd_fire) begin
        out_valid_d = 1'b1;
        out_grad_d  = rd_mask ? bus.bwd_grad : 32'h0000_0000;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and output state; reset drops stored masks and in-flight output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
`ifndef RELU_MASK_LIFO_EN
      rd_ptr_q    <= '0;
`endif
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
`ifndef RELU_MASK_LIFO_EN
      rd_ptr_q    <= rd_ptr_d;
`endif
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_grad_q  <= out_grad_d;
    end
  end

  // Mask bit storage; contents are meaningless once count is zeroed.
  always_ff @(posedge clk) begin
    if (fwd_fire) mask_q[wr_ptr_q] <= fwd_mask;
  end

endmodule

// File: tb/tb_relu_mask_buffer.sv
// tb_relu_mask_buffer: randomized and directed traffic against a queue-based
// reference model; a monitor compares every transferred gradient.
module tb_relu_mask_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   n_checks = 0;
  int   n_errors = 0;

  relu_mask_buffer_if #(.DEPTH(DEPTH)) bus ();

  relu_mask_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A float is strictly positive when its sign is clear and it is not +0.0.
  function automatic bit is_positive(input logic [31:0] v);
    return (v[31] == 1'b0) && (v != 32'h0000_0000);
  endfunction

  // Reference model: stored masks as a plain queue, pending outputs as a queue.
  bit          mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] seen[$];
  bit          m_ov = 0;
  bit          hold_vld = 0;
  logic [31:0] hold_grad;
  int          cnt;
  bit          m_fwd_rdy, m_bwd_rdy, fwd_go, bwd_go, mk;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete(); exp_q.delete(); m_ov = 0; hold_vld = 0;
    end else begin
      cnt = mq.size();
      m_bwd_rdy = (cnt != 0) && (!m_ov || bus.out_ready);
`ifdef RELU_MASK_LIFO_EN
      m_fwd_rdy = (cnt != DEPTH) && !(bus.bwd_valid && m_bwd_rdy);
`else
      m_fwd_rdy = (cnt != DEPTH);
`endif
      check("fwd_ready", 32'(bus.fwd_ready), 32'(m_fwd_rdy));
      check("bwd_ready", 32'(bus.bwd_ready), 32'(m_bwd_rdy));
      check("mask_count", 32'(bus.mask_count), 32'(cnt));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      if (hold_vld) check("stall_hold", bus.out_grad, hold_grad);
      hold_vld  = m_ov && !bus.out_ready;
      hold_grad = bus.out_grad;
      if (m_ov && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", bus.out_grad, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("out_grad", bus.out_grad, e);
          seen.push_back(bus.out_grad);
        end
      end
      if (clear) begin
        mq.delete(); exp_q.delete(); m_ov = 0; hold_vld = 0;
      end else begin
        fwd_go = bus.fwd_valid && m_fwd_rdy;
        bwd_go = bus.bwd_valid && m_bwd_rdy;
        if (bwd_go) begin
`ifdef RELU_MASK_LIFO_EN
          mk = mq.pop_back();
`else
          mk = mq.pop_front();
`endif
          exp_q.push_back(mk ? bus.bwd_grad : 32'h0000_0000);
          m_ov = 1;
        end else if (bus.out_ready) begin
          m_ov = 0;
        end
        if (fwd_go) mq.push_back(is_positive(bus.fwd_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.fwd_valid = 0; bus.bwd_valid = 0; clear = 0;
  endtask

  function automatic logic [31:0] rnd_mag(input bit sign);
    return {sign, 31'($urandom_range(1, 32'h7FFF_FFFF))};
  endfunction

  logic [31:0] p1_data [4];
  logic [31:0] p1_exp  [4];

  initial begin
    p1_data[0] = 32'h3F80_0000; p1_data[1] = 32'hBF80_0000;
    p1_data[2] = 32'h0000_0000; p1_data[3] = 32'h8000_0000;
`ifdef RELU_MASK_LIFO_EN
    p1_exp[0] = 32'h0; p1_exp[1] = 32'h0; p1_exp[2] = 32'h0; p1_exp[3] = 32'h4000_0000;
`else
    p1_exp[0] = 32'h4000_0000; p1_exp[1] = 32'h0; p1_exp[2] = 32'h0; p1_exp[3] = 32'h0;
`endif
    reset = 0; clear = 0;
    bus.fwd_valid = 0; bus.fwd_data = '0; bus.bwd_valid = 0; bus.bwd_grad = '0;
    bus.out_ready = 1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_grad", bus.out_grad, 32'd0);
    check("rst_mask_count", 32'(bus.mask_count), 32'd0);
    check("rst_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("rst_bwd_ready", 32'(bus.bwd_ready), 32'd0);
    tick(); tick();
    reset = 1;
    tick();

    // Directed mask-rule sequence.
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = p1_data[i]; tick();
    end
    idle();
    bus.bwd_valid = 1; bus.bwd_grad = 32'h4000_0000;
    for (int i = 0; i < 4; i++) tick();
    idle(); tick(); tick(); tick();
    check("p1_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) check($sformatf("p1_out%0d", i), seen[i], p1_exp[i]);

    // Fill to DEPTH, then drain one.
    for (int i = 0; i < DEPTH; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(1'b0); tick();
    end
    idle();
    check("full_count", 32'(bus.mask_count), 32'(DEPTH));
    check("full_fwd_ready", 32'(bus.fwd_ready), 32'd0);
    bus.bwd_valid = 1; bus.bwd_grad = $urandom; tick();
    idle();
    check("drain1_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("drain1_count", 32'(bus.mask_count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.bwd_valid = 1; bus.bwd_grad = $urandom; tick();
    end
    idle(); tick(); tick();

    // Steady state at count 3 with simultaneous handshakes, wrapping pointers.
    for (int i = 0; i < 3; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(i[0]); tick();
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(i[0]);
      bus.bwd_valid = 1; bus.bwd_grad = $urandom;
      tick();
    end
    idle();
`ifndef RELU_MASK_LIFO_EN
    check("steady_count", 32'(bus.mask_count), 32'd3);
`endif
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.bwd_valid = 1; bus.bwd_grad = $urandom; tick();
    end
    idle(); tick(); tick();

    // Output back-pressure.
    for (int i = 0; i < 4; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(1'b0); tick();
    end
    idle();
    bus.out_ready = 0; bus.bwd_valid = 1; bus.bwd_grad = 32'h1234_5678;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.bwd_grad = $urandom; tick();
    end
    check("stall_count", 32'(bus.mask_count), 32'd3);
    check("stall_bwd_ready", 32'(bus.bwd_ready), 32'd0);
    check("stall_grad", bus.out_grad, 32'h1234_5678);
    bus.out_ready = 1; tick();
    check("release_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    idle(); tick(); tick();

    // clear against simultaneous handshakes at count 10.
    for (int i = 0; i < 10; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(1'b0); tick();
    end
    bus.bwd_valid = 1; bus.bwd_grad = $urandom; clear = 1; tick();
    idle();
    check("clear_count", 32'(bus.mask_count), 32'd0);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);
    check("clear_out_grad", bus.out_grad, 32'd0);
    check("clear_bwd_ready", 32'(bus.bwd_ready), 32'd0);
    tick();

    // Randomized mixed traffic.
    for (int i = 0; i < 600; i++) begin
      bus.fwd_valid = 1'($urandom_range(0, 1));
      bus.fwd_data  = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), 31'h0}
                                                  : 32'($urandom);
      bus.bwd_valid = 1'($urandom_range(0, 1));
      bus.bwd_grad  = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clear         = ($urandom_range(0, 49) == 0);
      tick();
    end

    // Asynchronous reset between edges while output is pending.
    idle(); bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.fwd_valid = 1; bus.fwd_data = rnd_mag(1'b0); tick();
    end
    bus.fwd_valid = 0; bus.bwd_valid = 1; bus.bwd_grad = 32'hCAFE_0001; tick();
    idle();
    #2 reset = 0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_grad", bus.out_grad, 32'd0);
    check("arst_mask_count", 32'(bus.mask_count), 32'd0);
    check("arst_bwd_ready", 32'(bus.bwd_ready), 32'd0);
    tick(); reset = 1; bus.out_ready = 1; tick();

    for (int i = 0; i < 100; i++) begin
      bus.fwd_valid = 1'($urandom_range(0, 1));
      bus.fwd_data  = 32'($urandom);
      bus.bwd_valid = 1'($urandom_range(0, 1));
      bus.bwd_grad  = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle(); bus.out_ready = 1; tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
